// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory load/store paths: size codes,
// storer FSM state encoding and the store alignment rule.
package data_memory_pkg;

    localparam logic [1:0] WORD = 2'b11;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        ERR
    } state_t;

    // The reserved size code 2'b10 never passes.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (size)
            WORD:    ok = (offset == 2'b00);
            HALF:    ok = (offset[0] == 1'b0);
            BYTE:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_merger.sv
// Combinational byte/half lane insertion into a read word; the inverse of
// the loader's little-endian lane extraction.
module data_memory_merger
    import data_memory_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [15:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    always_comb begin
        merged = rdata;
        case (size)
            BYTE: merged[{offset, 3'b000} +: 8] = data[7:0];
            HALF: begin
                if (offset[1])
                    merged[31:16] = data;
                else
                    merged[15:0] = data;
            end
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/data_memory_storer.sv
// Store path to a word-wide RAM without byte enables: word stores write
// directly, byte/half stores go through read-modify-write.
module data_memory_storer
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       data_in,
    input  logic [1:0]        size_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [ADDR_W-3:0] mem_addr_out,
    output logic              mem_re_out,
    input  logic [31:0]       mem_rdata_in,
    output logic              mem_we_out,
    output logic [31:0]       mem_wdata_out
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [31:0]       merge_q;
    logic [31:0]       merged;

    data_memory_merger u_merger (
        .rdata  (mem_rdata_in),
        .data   (data_q[15:0]),
        .size   (size_q),
        .offset (addr_q[1:0]),
        .merged (merged)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            merge_q <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_in) begin
                addr_q <= addr_in;
                data_q <= data_in;
                size_q <= size_in;
            end
            if (state == WAIT)
                merge_q <= merged;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_in) begin
                    if (!is_aligned(size_in, addr_in[1:0]))
                        next_state = ERR;
                    else if (size_in == WORD)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = WAIT;
            WAIT:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are qualified by reset so nothing reaches memory in a reset cycle.
    always_comb begin
        busy_out      = (state != IDLE);
        mem_re_out    = rst_n_in && (state == READ);
        mem_we_out    = rst_n_in && (state == WRITE);
        done_out      = mem_we_out;
        err_out       = rst_n_in && (state == ERR);
        mem_addr_out  = addr_q[ADDR_W-1:2];
        mem_wdata_out = '0;
        if (state == WRITE)
            mem_wdata_out = (size_q == WORD) ? data_q : merge_q;
    end

endmodule

// File: tb/tb_data_memory_storer.sv
// Directed bench for data_memory_storer with a RAM model and a write/error
// scoreboard checked by an independent monitor.
module tb_data_memory_storer;

    localparam logic [1:0] SZ_WORD = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_RSVD = 2'b10;

    typedef struct {
        bit          isErr;
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  size_in;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [29:0] mem_addr_out;
    logic        mem_re_out;
    logic [31:0] mem_rdata_in;
    logic        mem_we_out;
    logic [31:0] mem_wdata_out;

    logic [31:0] mem [0:63];
    logic        plWe;
    logic [5:0]  plAddr;
    logic [31:0] plData;

    exp_t expQ[$];
    int   checkCount = 0;
    int   errorCount = 0;

    data_memory_storer #(.ADDR_W(32)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_in        (req_in),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .size_in       (size_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .err_out       (err_out),
        .mem_addr_out  (mem_addr_out),
        .mem_re_out    (mem_re_out),
        .mem_rdata_in  (mem_rdata_in),
        .mem_we_out    (mem_we_out),
        .mem_wdata_out (mem_wdata_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM model: read data one cycle after the strobe.
    always @(posedge clk_in) begin
        if (plWe)
            mem[plAddr] <= plData;
        else if (mem_we_out)
            mem[mem_addr_out[5:0]] <= mem_wdata_out;
        if (mem_re_out)
            mem_rdata_in <= mem[mem_addr_out[5:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write or error pulse must match the next expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (mem_we_out) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL sb_unexpected_write: got addr %h data %h, expected none", mem_addr_out, mem_wdata_out);
            end else begin
                e = expQ.pop_front();
                if (e.isErr || mem_addr_out !== e.addr || mem_wdata_out !== e.data || done_out !== 1'b1) begin
                    errorCount++;
                    $display("[TB] FAIL sb_write: got addr %h data %h done %b, expected err %0b addr %h data %h done 1",
                             mem_addr_out, mem_wdata_out, done_out, e.isErr, e.addr, e.data);
                end
            end
        end else if (err_out) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL sb_unexpected_err: got err 1, expected none");
            end else begin
                e = expQ.pop_front();
                if (!e.isErr || mem_re_out !== 1'b0) begin
                    errorCount++;
                    $display("[TB] FAIL sb_err: got err with re %b, expected write addr %h data %h", mem_re_out, e.addr, e.data);
                end
            end
        end
    end

    task automatic expectWrite(input logic [29:0] a, input logic [31:0] d);
        exp_t e;
        e.isErr = 1'b0;
        e.addr  = a;
        e.data  = d;
        expQ.push_back(e);
    endtask

    task automatic expectErr();
        exp_t e;
        e.isErr = 1'b1;
        e.addr  = '0;
        e.data  = '0;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_in  = 1'b1;
        addr_in = a;
        data_in = d;
        size_in = s;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        plWe   = 1'b1;
        plAddr = a;
        plData = d;
        @(negedge clk_in);
        plWe   = 1'b0;
    endtask

    task automatic errorCase(input string name, input logic [31:0] a, input logic [1:0] s);
        applyStimulus(a, 32'h0BAD_0BAD, s);
        expectErr();
        @(negedge clk_in);
        req_in = 1'b0;
        checkOutput({name, "_err"}, {31'd0, err_out}, 32'd1);
        checkOutput({name, "_strobes"}, {30'd0, mem_re_out, mem_we_out}, 32'd0);
        @(negedge clk_in);
        checkOutput({name, "_idle"}, {30'd0, busy_out, err_out}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem_rdata_in = 32'h0;
        plWe     = 1'b0;
        plAddr   = '0;
        plData   = '0;
        rst_n_in = 1'b0;
        req_in   = 1'b0;
        addr_in  = 32'h0;
        data_in  = 32'h0;
        size_in  = SZ_WORD;
        repeat (2) @(negedge clk_in);

        checkOutput("reset_flags", {27'd0, busy_out, done_out, err_out, mem_re_out, mem_we_out}, 32'd0);
        checkOutput("reset_addr", {2'b00, mem_addr_out}, 32'd0);
        checkOutput("reset_wdata", mem_wdata_out, 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("idle_after_reset", {27'd0, busy_out, done_out, err_out, mem_re_out, mem_we_out}, 32'd0);

        preload(6'd4, 32'h1122_3344);
        preload(6'd8, 32'h1122_3344);
        preload(6'd12, 32'hAABB_CCDD);
        preload(6'd20, 32'h9988_7766);

        // Aligned word store
        applyStimulus(32'h10, 32'hDEAD_BEEF, SZ_WORD);
        expectWrite(30'h4, 32'hDEAD_BEEF);
        @(negedge clk_in);
        req_in = 1'b0;
        checkOutput("word_we_done", {30'd0, mem_we_out, done_out}, 32'd3);
        checkOutput("word_no_re", {31'd0, mem_re_out}, 32'd0);
        checkOutput("word_addr", {2'b00, mem_addr_out}, 32'h4);
        checkOutput("word_wdata", mem_wdata_out, 32'hDEAD_BEEF);
        @(negedge clk_in);
        checkOutput("word_idle", {31'd0, busy_out}, 32'd0);
        checkOutput("word_mem", mem[4], 32'hDEAD_BEEF);
        preload(6'd4, 32'h1122_3344);

        // Byte store at offset 3
        applyStimulus(32'h13, 32'h0000_00AB, SZ_BYTE);
        expectWrite(30'h4, 32'hAB22_3344);
        @(negedge clk_in);
        req_in = 1'b0;
        checkOutput("byte_read", {29'd0, busy_out, mem_re_out, mem_we_out}, 32'b110);
        checkOutput("byte_raddr", {2'b00, mem_addr_out}, 32'h4);
        @(negedge clk_in);
        checkOutput("byte_wait", {29'd0, busy_out, mem_re_out, mem_we_out}, 32'b100);
        @(negedge clk_in);
        checkOutput("byte_write", {29'd0, busy_out, mem_we_out, done_out}, 32'b111);
        checkOutput("byte_wdata", mem_wdata_out, 32'hAB22_3344);
        @(negedge clk_in);
        checkOutput("byte_idle", {31'd0, busy_out}, 32'd0);

        // Upper half store
        applyStimulus(32'h22, 32'h0000_CAFE, SZ_HALF);
        expectWrite(30'h8, 32'hCAFE_3344);
        @(negedge clk_in);
        req_in = 1'b0;
        checkOutput("half_busy_t1", {31'd0, busy_out}, 32'd1);
        @(negedge clk_in);
        checkOutput("half_busy_t2", {31'd0, busy_out}, 32'd1);
        @(negedge clk_in);
        checkOutput("half_busy_t3", {31'd0, busy_out}, 32'd1);
        checkOutput("half_wdata", mem_wdata_out, 32'hCAFE_3344);
        @(negedge clk_in);
        checkOutput("half_idle", {31'd0, busy_out}, 32'd0);

        errorCase("half_misaligned", 32'h21, SZ_HALF);
        errorCase("word_misaligned", 32'h22, SZ_WORD);
        errorCase("size_reserved", 32'h30, SZ_RSVD);

        // Byte store followed by a word request held through busy
        applyStimulus(32'h31, 32'h0000_0055, SZ_BYTE);
        expectWrite(30'hC, 32'hAABB_55DD);
        expectWrite(30'h10, 32'h1234_5678);
        @(negedge clk_in);
        applyStimulus(32'h40, 32'h1234_5678, SZ_WORD);
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("b2b_byte_write", {31'd0, mem_we_out}, 32'd1);
        @(negedge clk_in);
        checkOutput("b2b_idle_t4", {30'd0, busy_out, mem_we_out}, 32'd0);
        @(negedge clk_in);
        req_in = 1'b0;
        checkOutput("b2b_word_write_t5", {31'd0, mem_we_out}, 32'd1);
        checkOutput("b2b_word_addr", {2'b00, mem_addr_out}, 32'h10);
        @(negedge clk_in);
        checkOutput("b2b_byte_mem", mem[12], 32'hAABB_55DD);

        // Reset during WAIT abandons the read-modify-write
        applyStimulus(32'h50, 32'h0000_1111, SZ_HALF);
        @(negedge clk_in);
        req_in = 1'b0;
        @(negedge clk_in);
        checkOutput("rst_in_wait", {29'd0, busy_out, mem_re_out, mem_we_out}, 32'b100);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        checkOutput("rst_flags", {27'd0, busy_out, done_out, err_out, mem_re_out, mem_we_out}, 32'd0);
        checkOutput("rst_addr", {2'b00, mem_addr_out}, 32'd0);
        checkOutput("rst_wdata", mem_wdata_out, 32'd0);
        repeat (3) @(negedge clk_in);
        checkOutput("rst_mem_unchanged", mem[20], 32'h9988_7766);
        checkOutput("sb_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_memory_storer.md
# data_memory_storer

Store-side counterpart to the data memory load path. It accepts a store request from the MEM stage (address, register data, size) and writes it to a word-wide synchronous data RAM that has no byte enables. Word stores are written directly. Byte and half stores use a read-modify-write sequence. Misaligned or reserved-size requests are rejected with an error pulse, and the pipeline is stalled while a request is in flight.

## Interface
- `ADDR_W`, default 32: byte address width. The memory word address is `addr[ADDR_W-1:2]`.
- `clk_in` in 1: clock, rising edge.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `req_in` in 1: store request. Sampled only while `busy_out`=0.
- `addr_in` in ADDR_W: byte address.
- `data_in` in 32: register data. The low byte or low half is used for sub-word stores.
- `size_in` in 2: store size, 2'b11 WORD, 2'b01 HALF, 2'b00 BYTE, 2'b10 reserved.
- `busy_out` out 1: request in flight; the pipeline stalls on it.
- `done_out` out 1: one-cycle pulse, asserted in the cycle the memory write is issued.
- `err_out` out 1: one-cycle pulse for a misaligned or reserved-size request.
- `mem_addr_out` out ADDR_W-2: memory word address.
- `mem_re_out` out 1: memory read strobe.
- `mem_rdata_in` in 32: read data, valid exactly 1 cycle after `mem_re_out`.
- `mem_we_out` out 1: memory write strobe.
- `mem_wdata_out` out 32: write data.

## Operation
- FSM states: IDLE, WRITE, READ, WAIT, ERR.
- **IDLE**: when `req_in`=1, latch `addr`, `data` and `size`.
  - Aligned WORD → WRITE.
  - Aligned HALF or BYTE → READ.
  - Otherwise → ERR.
- **Alignment rules**:
  - WORD requires `offset`=00.
  - HALF requires `offset` ∈ {00, 10}.
  - BYTE accepts any offset.
  - `size`=10 is always an error.
- **READ**: `mem_re_out`=1 with the latched word address → WAIT.
- **WAIT**: capture `merge(mem_rdata_in, data, size, offset)` into a register → WRITE.
- **WRITE**: `mem_we_out`=1 and `done_out`=1 → IDLE.
  - WORD write data is `data`.
  - Sub-word write data is the merged register.
- **ERR**: `err_out`=1, no memory strobe → IDLE. The request is dropped.
- **Merge** (little-endian lanes, matching the load path):
  - BYTE at offset k: replace bits [8k+7:8k] with `data[7:0]`.
  - HALF at offset 00: replace [15:0] with `data[15:0]`.
  - HALF at offset 10: replace [31:16] with `data[15:0]`.
  - All other bits keep the read value.
- `busy_out` = (state ≠ IDLE).
- `mem_addr_out` always drives the latched word address. It is 0 in IDLE after reset.
- A request is never accepted in the same cycle a write is issued; the next acceptance is in IDLE.

## Timing
- Accept edge: the T edge, with `req_in`=1 in IDLE.
- Aligned WORD: WRITE in cycle T+1. Latency 1; next request can be accepted at T+2.
- Aligned sub-word:
  - READ in T+1.
  - `mem_rdata_in` valid in T+2 (WAIT).
  - WRITE in T+3.
  - Latency 3; next request can be accepted at T+4.
- Error: `err_out` in T+1, back to IDLE at T+2.
- Reset values:
  - State IDLE.
  - `busy_out`, `done_out`, `err_out`, `mem_re_out`, `mem_we_out` all 0.
  - `mem_addr_out` and `mem_wdata_out` 0.
  - Latched fields and merge register 0.
- Reset mid-operation:
  - In the cycle `rst_n_in`=0 is sampled, no write issues.
  - An in-flight RMW is abandoned and memory is left unmodified.
- `req_in` while `busy_out`=1 is ignored. The pipeline holds the request until `busy_out` falls.
- `mem_rdata_in` is ignored outside WAIT.

## Structure
- Package `data_memory_pkg`:
  - Size localparams WORD=2'b11, HALF=2'b01, BYTE=2'b00, shared with the load path.
  - State encoding.
  - Alignment-check function.
- Sub-module `data_memory_merger`: combinational merge of read word, store data, size and offset. It is the exact inverse lane mapping of the loader and is unit-testable alone.
- Top level: FSM, request latches, merge register, memory strobes.

## Test plan
- WORD: `addr`=0x10, `data`=0xDEADBEEF → T+1: `mem_we_out`=1, `mem_addr_out`=0x4, `mem_wdata_out`=0xDEADBEEF, `done_out`=1; no read strobe.
- BYTE: `addr`=0x13, `data`=0x000000AB, memory word 0x11223344 → READ at T+1, WRITE at T+3 with 0xAB223344.
- HALF: `addr`=0x22, `data`=0x0000CAFE, memory word 0x11223344 → write 0xCAFE3344 at T+3; `busy_out` high T+1..T+3.
- Misaligned and reserved requests → `err_out` at T+1, no `mem_re_out` or `mem_we_out`, IDLE at T+2:
  - HALF at `addr`=0x21.
  - WORD at `addr`=0x22.
  - `size`=10.
- Back-to-back: BYTE followed by a held WORD request → the WORD is accepted at T+4 and its write issues at T+5.
- Reset: `rst_n_in`=0 during WAIT → no `mem_we_out`, all outputs 0 the next cycle, memory unchanged.
